bp_cce_lce_cmd_arb: RTL

BP_CCE_LCE_CMD_ARB -- requirements
Module: bp_cce_lce_cmd_arb

---
 rtl/bp_cce_lce_cmd_arb_if.sv | 51 +++++
 rtl/bp_cce_lce_cmd_arb.sv | 131 +++++++++++++
 2 files changed

// File: rtl/bp_cce_lce_cmd_arb_if.sv
// Purpose: LCE command arbiter bundle (microcode source, message-unit source, LCE command sink, status).
// Latency: bundle only, no timing of its own.
// Backpressure: sources see yumi (beat consumed); the sink drives ready_and.
// Ports: ucode_* / msg_* source beats with header, data, valid, last and yumi back;
//        lce_cmd_* outbound beat with ready_and back; ucode_busy_o and owner_o status.
// Modports: slave = arbiter side, master = environment side.
interface bp_cce_lce_cmd_arb_if #(
  parameter int hdr_width_p  = 64,
  parameter int data_width_p = 64
);
  logic [hdr_width_p-1:0]  ucode_hdr_i;
  logic [data_width_p-1:0] ucode_data_i;
  logic                    ucode_v_i;
  logic                    ucode_last_i;
  logic                    ucode_yumi_o;

  logic [hdr_width_p-1:0]  msg_hdr_i;
  logic [data_width_p-1:0] msg_data_i;
  logic                    msg_v_i;
  logic                    msg_last_i;
  logic                    msg_yumi_o;

  logic [hdr_width_p-1:0]  lce_cmd_header_o;
  logic [data_width_p-1:0] lce_cmd_data_o;
  logic                    lce_cmd_v_o;
  logic                    lce_cmd_last_o;
  logic                    lce_cmd_ready_and_i;

  logic                    ucode_busy_o;
  logic [1:0]              owner_o;

  modport slave (
    input  ucode_hdr_i, ucode_data_i, ucode_v_i, ucode_last_i,
    output ucode_yumi_o,
    input  msg_hdr_i, msg_data_i, msg_v_i, msg_last_i,
    output msg_yumi_o,
    output lce_cmd_header_o, lce_cmd_data_o, lce_cmd_v_o, lce_cmd_last_o,
    input  lce_cmd_ready_and_i,
    output ucode_busy_o, owner_o
  );

  modport master (
    output ucode_hdr_i, ucode_data_i, ucode_v_i, ucode_last_i,
    input  ucode_yumi_o,
    output msg_hdr_i, msg_data_i, msg_v_i, msg_last_i,
    input  msg_yumi_o,
    input  lce_cmd_header_o, lce_cmd_data_o, lce_cmd_v_o, lce_cmd_last_o,
    output lce_cmd_ready_and_i,
    input  ucode_busy_o, owner_o
  );
endinterface

// File: rtl/bp_cce_lce_cmd_arb.sv
// Purpose: arbitrates microcode and message-unit LCE command beats onto one outbound LCE command port.
// Latency: zero cycles; outbound beat and yumi are combinational from the selected source.
// Backpressure: yumi only when outbound valid meets ready_and; multi-beat messages lock the port.
// Ports: clk_i, reset_i (async, active-high); bus (slave modport) carries both source beats,
//        the outbound beat, ucode_busy_o (microcode command cannot issue) and owner_o {msg, ucode}.
module bp_cce_lce_cmd_arb #(
  parameter int hdr_width_p    = 64,
  parameter int data_width_p   = 64,
  parameter int starve_limit_p = 4
) (
  input logic                  clk_i,
  input logic                  reset_i,
  bp_cce_lce_cmd_arb_if.slave  bus
);

  typedef enum logic [1:0] {
    E_IDLE       = 2'd0,
    E_LOCK_UCODE = 2'd1,
    E_LOCK_MSG   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SEL_NONE  = 2'd0,
    SEL_UCODE = 2'd1,
    SEL_MSG   = 2'd2
  } sel_e;

  localparam logic [3:0] starve_lim_lp = 4'(starve_limit_p);

  state_e                  state_q, state_d;
  logic [3:0]              starve_cnt_q, starve_cnt_d;
  sel_e                    sel;
  logic                    sel_v;
  logic                    sel_last;
  logic [hdr_width_p-1:0]  sel_hdr;
  logic [data_width_p-1:0] sel_data;
  logic                    accept;
  logic                    busy;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= E_IDLE;
      starve_cnt_q <= 4'd0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  always_comb begin
    sel          = SEL_NONE;
    sel_v        = 1'b0;
    sel_last     = 1'b0;
    sel_hdr      = '0;
    sel_data     = '0;
    accept       = 1'b0;
    busy         = 1'b0;
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;

    // Nothing is selected while reset is held so every output reads zero
    // without waiting for a clock edge.
    if (!reset_i) begin
      unique case (state_q)
        E_IDLE: begin
          // Message unit normally wins; microcode gets the port once the
          // message unit has taken starve_limit_p first beats in a row.
          if (bus.msg_v_i && (!bus.ucode_v_i || (starve_cnt_q < starve_lim_lp)))
            sel = SEL_MSG;
          else if (bus.ucode_v_i)
            sel = SEL_UCODE;
        end
        E_LOCK_UCODE: sel = SEL_UCODE;
        E_LOCK_MSG:   sel = SEL_MSG;
        default:      sel = SEL_NONE;
      endcase
    end

    unique case (sel)
      SEL_UCODE: begin
        sel_v    = bus.ucode_v_i;
        sel_last = bus.ucode_last_i;
        sel_hdr  = bus.ucode_hdr_i;
        sel_data = bus.ucode_data_i;
      end
      SEL_MSG: begin
        sel_v    = bus.msg_v_i;
        sel_last = bus.msg_last_i;
        sel_hdr  = bus.msg_hdr_i;
        sel_data = bus.msg_data_i;
      end
      default: ;
    endcase

    accept = sel_v & bus.lce_cmd_ready_and_i;

    busy = !reset_i &&
           ((state_q == E_LOCK_MSG) ||
            ((state_q == E_IDLE) && (sel == SEL_MSG)) ||
            ((sel == SEL_UCODE) && !bus.lce_cmd_ready_and_i));

    unique case (state_q)
      E_IDLE: begin
        // A non-final first beat locks the port to its source.
        if (accept && !sel_last)
          state_d = (sel == SEL_UCODE) ? E_LOCK_UCODE : E_LOCK_MSG;
        if (!bus.ucode_v_i)
          starve_cnt_d = 4'd0;
        else if (accept && (sel == SEL_MSG) && (starve_cnt_q < starve_lim_lp))
          starve_cnt_d = starve_cnt_q + 4'd1;
        else if (accept && (sel == SEL_UCODE))
          starve_cnt_d = 4'd0;
      end
      E_LOCK_UCODE, E_LOCK_MSG: begin
        if (accept && sel_last)
          state_d = E_IDLE;
      end
      default: state_d = E_IDLE;
    endcase
  end

  assign bus.lce_cmd_v_o      = sel_v;
  assign bus.lce_cmd_last_o   = sel_last;
  assign bus.lce_cmd_header_o = sel_hdr;
  assign bus.lce_cmd_data_o   = sel_data;
  assign bus.ucode_yumi_o     = accept && (sel == SEL_UCODE);
  assign bus.msg_yumi_o       = accept && (sel == SEL_MSG);
  assign bus.ucode_busy_o     = busy;
  assign bus.owner_o          = {state_q == E_LOCK_MSG, state_q == E_LOCK_UCODE};

endmodule
